// File: rtl/fifo_flagged.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, optional show-ahead read, synchronous flush and sticky error flags.
module fifo_flagged #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = SIZE - 2,
  parameter int AE_LEVEL   = 2,
  parameter int SHOW_AHEAD = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      rden,
  output logic [DATA_WIDTH-1:0]     rddata,
  output logic                      rddone,
  input  logic                      wren,
  input  logic [DATA_WIDTH-1:0]     wrdata,
  output logic                      wrdone,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic                      overflow,
  output logic                      underflow,
  output logic [$clog2(SIZE+1)-1:0] num_used,
  output logic [$clog2(SIZE+1)-1:0] num_free
);

  localparam int CW = $clog2(SIZE + 1);
  localparam int PW = $clog2(SIZE);
  localparam logic [CW-1:0] SIZE_C   = CW'(SIZE);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_PTR = PW'(SIZE - 1);
  localparam logic          AF_RESET = (AF_LEVEL == 0);

  logic [DATA_WIDTH-1:0] mem [SIZE];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] free_reg;
  logic          empty_reg, full_reg, ae_reg, af_reg;
  logic          ovf_reg, ovf_next;
  logic          udf_reg, udf_next;
  logic          rddone_reg, wrdone_reg;
  logic          write_ok, read_ok;

  // Acceptance looks only at registered state, so a simultaneous read cannot
  // make room for a write in the same cycle (and vice versa at empty).
  always_comb begin
    write_ok    = wren & ~full_reg & ~flush;
    read_ok     = rden & ~empty_reg & ~flush;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (write_ok) wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      if (read_ok)  rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
    end
    count_next = flush ? '0 : count_reg + CW'(write_ok) - CW'(read_ok);
    ovf_next   = ~flush & (ovf_reg | (wren & full_reg));
    udf_next   = ~flush & (udf_reg | (rden & empty_reg));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      free_reg   <= SIZE_C;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
      ae_reg     <= 1'b1;
      af_reg     <= AF_RESET;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
      rddone_reg <= 1'b0;
      wrdone_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      free_reg   <= SIZE_C - count_next;
      empty_reg  <= (count_next == '0);
      full_reg   <= (count_next == SIZE_C);
      ae_reg     <= (count_next <= AE_C);
      af_reg     <= (count_next >= AF_C);
      ovf_reg    <= ovf_next;
      udf_reg    <= udf_next;
      rddone_reg <= read_ok;
      wrdone_reg <= write_ok;
    end
  end

  // Storage has no reset so it maps onto block RAM; flush leaves it intact.
  always_ff @(posedge clk) begin
    if (write_ok) mem[wr_ptr_reg] <= wrdata;
  end

  generate
    if (SHOW_AHEAD != 0) begin : g_show_ahead
      // Gated to zero while empty so the reset value of rddata is well defined.
      assign rddata = empty_reg ? '0 : mem[rd_ptr_reg];
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] rddata_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)        rddata_reg <= '0;
        else if (read_ok) rddata_reg <= mem[rd_ptr_reg];
      end
      assign rddata = rddata_reg;
    end
  endgenerate

  assign rddone       = rddone_reg;
  assign wrdone       = wrdone_reg;
  assign empty        = empty_reg;
  assign full         = full_reg;
  assign almost_empty = ae_reg;
  assign almost_full  = af_reg;
  assign overflow     = ovf_reg;
  assign underflow    = udf_reg;
  assign num_used     = count_reg;
  assign num_free     = free_reg;

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: default-size table run, SIZE=5 wrap run and a
// show-ahead run, each with a data scoreboard, plus flush and async reset.
module tb_fifo_flagged;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b0;

  int checks = 0;
  int failures = 0;

  // default instance (SIZE 16, registered read)
  logic       d_flush = 0, d_rden = 0, d_wren = 0;
  logic [7:0] d_wrdata = 0, d_rddata;
  logic       d_rddone, d_wrdone, d_empty, d_full, d_ae, d_af, d_ovf, d_udf;
  logic [4:0] d_used, d_free;

  fifo_flagged u_dut (
    .clk(clk), .reset(reset), .flush(d_flush), .rden(d_rden), .rddata(d_rddata),
    .rddone(d_rddone), .wren(d_wren), .wrdata(d_wrdata), .wrdone(d_wrdone),
    .empty(d_empty), .full(d_full), .almost_empty(d_ae), .almost_full(d_af),
    .overflow(d_ovf), .underflow(d_udf), .num_used(d_used), .num_free(d_free));

  // SIZE 5 instance for pointer wrap
  logic       w_flush = 0, w_rden = 0, w_wren = 0;
  logic [7:0] w_wrdata = 0, w_rddata;
  logic       w_rddone, w_wrdone, w_empty, w_full, w_ae, w_af, w_ovf, w_udf;
  logic [2:0] w_used, w_free;

  fifo_flagged #(.SIZE(5)) u_wrap (
    .clk(clk), .reset(reset), .flush(w_flush), .rden(w_rden), .rddata(w_rddata),
    .rddone(w_rddone), .wren(w_wren), .wrdata(w_wrdata), .wrdone(w_wrdone),
    .empty(w_empty), .full(w_full), .almost_empty(w_ae), .almost_full(w_af),
    .overflow(w_ovf), .underflow(w_udf), .num_used(w_used), .num_free(w_free));

  // show-ahead instance
  logic       s_flush = 0, s_rden = 0, s_wren = 0;
  logic [7:0] s_wrdata = 0, s_rddata;
  logic       s_rddone, s_wrdone, s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
  logic [4:0] s_used, s_free;

  fifo_flagged #(.SHOW_AHEAD(1)) u_sa (
    .clk(clk), .reset(reset), .flush(s_flush), .rden(s_rden), .rddata(s_rddata),
    .rddone(s_rddone), .wren(s_wren), .wrdata(s_wrdata), .wrdone(s_wrdone),
    .empty(s_empty), .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
    .overflow(s_ovf), .underflow(s_udf), .num_used(s_used), .num_free(s_free));

  typedef struct {
    logic       wren;
    logic       rden;
    logic [7:0] wrdata;
    logic       exp_wrdone;
    logic       exp_rddone;
    logic [4:0] exp_used;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_af;
    logic       exp_ae;
    logic       exp_ovf;
    logic       exp_udf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  logic [7:0] wq[$];
  int         wm = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic [7:0] d,
                              input logic ew, input logic er, input int used,
                              input logic ovf, input logic udf);
    vec_t v;
    v.wren = w; v.rden = r; v.wrdata = d;
    v.exp_wrdone = ew; v.exp_rddone = er;
    v.exp_used  = 5'(used);
    v.exp_full  = (used == 16);
    v.exp_empty = (used == 0);
    v.exp_af    = (used >= 14);
    v.exp_ae    = (used <= 2);
    v.exp_ovf   = ovf; v.exp_udf = udf;
    return v;
  endfunction

  task automatic d_pop_check(input string name);
    logic [7:0] e;
    if (d_rddone) begin
      if (sb.size() == 0) begin
        chk({name, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({name, ".rddata"}, d_rddata, e);
      end
    end
  endtask

  task automatic w_op(input logic wr, input logic rd, input logic [7:0] d, input int k);
    logic exp_w, exp_r;
    logic [7:0] e;
    exp_w = wr && (wm < 5);
    exp_r = rd && (wm > 0);
    w_wren = wr; w_rden = rd; w_wrdata = d;
    if (exp_w) wq.push_back(d);
    tick();
    w_wren = 0; w_rden = 0;
    wm = wm + int'(exp_w) - int'(exp_r);
    $display("wrap txn %0d wr=%0b rd=%0b used=%0d", k, wr, rd, w_used);
    chk($sformatf("w%0d.wrdone", k), w_wrdone, exp_w);
    chk($sformatf("w%0d.rddone", k), w_rddone, exp_r);
    chk($sformatf("w%0d.used", k), w_used, wm);
    chk($sformatf("w%0d.free", k), w_free, 5 - wm);
    chk($sformatf("w%0d.full", k), w_full, wm == 5);
    chk($sformatf("w%0d.bound", k), w_used <= 3'd5, 1);
    if (w_rddone) begin
      if (wq.size() == 0) chk($sformatf("w%0d.sb_empty", k), 32'd1, 32'd0);
      else begin
        e = wq.pop_front();
        chk($sformatf("w%0d.rddata", k), w_rddata, e);
      end
    end
  endtask

  initial begin
    // table: fill, overflow, drain, underflow, simultaneous at empty and full
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1, 0, 8'(i), 1, 0, i + 1, 0, 0));
    vecs.push_back(mk(1, 0, 8'hEE, 0, 0, 16, 1, 0));
    for (int i = 0; i < 16; i++) vecs.push_back(mk(0, 1, 8'h00, 0, 1, 15 - i, 1, 0));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 8'h40, 1, 0, 1, 1, 1));
    for (int i = 1; i < 16; i++) vecs.push_back(mk(1, 0, 8'(8'h40 + i), 1, 0, 1 + i, 1, 1));
    vecs.push_back(mk(1, 1, 8'h99, 0, 1, 15, 1, 1));

    #1 reset = 1'b1;
    #6;
    chk("rst.empty", d_empty, 1);   chk("rst.full", d_full, 0);
    chk("rst.ae", d_ae, 1);         chk("rst.af", d_af, 0);
    chk("rst.used", d_used, 0);     chk("rst.free", d_free, 16);
    chk("rst.rddone", d_rddone, 0); chk("rst.wrdone", d_wrdone, 0);
    chk("rst.ovf", d_ovf, 0);       chk("rst.udf", d_udf, 0);
    chk("rst.rddata", d_rddata, 0); chk("rst.w_free", w_free, 5);
    chk("rst.s_rddata", s_rddata, 0);
    #4 reset = 1'b0;

    foreach (vecs[i]) begin
      d_wren = vecs[i].wren; d_rden = vecs[i].rden; d_wrdata = vecs[i].wrdata;
      if (vecs[i].exp_wrdone) sb.push_back(vecs[i].wrdata);
      tick();
      $display("txn %0d wr=%0b rd=%0b data=%02h used=%0d", i, vecs[i].wren, vecs[i].rden,
               vecs[i].wrdata, d_used);
      chk($sformatf("v%0d.wrdone", i), d_wrdone, vecs[i].exp_wrdone);
      chk($sformatf("v%0d.rddone", i), d_rddone, vecs[i].exp_rddone);
      chk($sformatf("v%0d.used", i), d_used, vecs[i].exp_used);
      chk($sformatf("v%0d.free", i), d_free, 5'd16 - vecs[i].exp_used);
      chk($sformatf("v%0d.full", i), d_full, vecs[i].exp_full);
      chk($sformatf("v%0d.empty", i), d_empty, vecs[i].exp_empty);
      chk($sformatf("v%0d.af", i), d_af, vecs[i].exp_af);
      chk($sformatf("v%0d.ae", i), d_ae, vecs[i].exp_ae);
      chk($sformatf("v%0d.ovf", i), d_ovf, vecs[i].exp_ovf);
      chk($sformatf("v%0d.udf", i), d_udf, vecs[i].exp_udf);
      d_pop_check($sformatf("v%0d", i));
    end
    d_wren = 0; d_rden = 0;
    tick();
    chk("hold.rddone", d_rddone, 0);
    chk("hold.rddata", d_rddata, 8'h40);

    // drain to 7 entries, then flush with rden and wren asserted
    for (int i = 0; i < 8; i++) begin
      d_rden = 1;
      tick();
      d_rden = 0;
      $display("drain txn %0d used=%0d", i, d_used);
      chk($sformatf("dr%0d.rddone", i), d_rddone, 1);
      d_pop_check($sformatf("dr%0d", i));
    end
    chk("pre_flush.used", d_used, 7);
    chk("pre_flush.ovf", d_ovf, 1);
    d_flush = 1; d_rden = 1; d_wren = 1; d_wrdata = 8'h77;
    tick();
    d_flush = 0; d_rden = 0; d_wren = 0;
    $display("flush txn used=%0d", d_used);
    chk("flush.empty", d_empty, 1);   chk("flush.used", d_used, 0);
    chk("flush.free", d_free, 16);    chk("flush.ovf", d_ovf, 0);
    chk("flush.udf", d_udf, 0);       chk("flush.rddone", d_rddone, 0);
    chk("flush.wrdone", d_wrdone, 0);
    sb.delete();

    // async reset in the middle of a write burst
    d_wren = 1; d_wrdata = 8'h11;
    tick();
    chk("mw1.wrdone", d_wrdone, 1); chk("mw1.used", d_used, 1);
    d_wrdata = 8'h12;
    tick();
    chk("mw2.wrdone", d_wrdone, 1); chk("mw2.used", d_used, 2);
    #2 reset = 1'b1; d_wren = 0;
    #1;
    $display("async reset txn used=%0d", d_used);
    chk("areset.wrdone", d_wrdone, 0); chk("areset.used", d_used, 0);
    chk("areset.empty", d_empty, 1);   chk("areset.free", d_free, 16);
    chk("areset.ae", d_ae, 1);         chk("areset.rddata", d_rddata, 0);
    #2 reset = 1'b0;

    // SIZE 5 wrap: prefill 4, 12 write/read pairs, drain
    for (int i = 0; i < 4; i++) w_op(1, 0, 8'(8'h50 + i), i);
    for (int k = 0; k < 12; k++) begin
      w_op(1, 0, 8'(8'h60 + k), 4 + 2 * k);
      w_op(0, 1, 8'h00, 5 + 2 * k);
    end
    for (int i = 0; i < 4; i++) w_op(0, 1, 8'h00, 28 + i);
    chk("wrap.empty", w_empty, 1);
    chk("wrap.sb_left", wq.size(), 0);

    // show-ahead
    s_wren = 1; s_wrdata = 8'hA5;
    tick();
    $display("sa txn write A5 rddata=%02h", s_rddata);
    chk("sa1.rddata", s_rddata, 8'hA5); chk("sa1.empty", s_empty, 0);
    chk("sa1.wrdone", s_wrdone, 1);
    s_wrdata = 8'h3C;
    tick();
    s_wren = 0;
    $display("sa txn write 3C rddata=%02h", s_rddata);
    chk("sa2.rddata", s_rddata, 8'hA5); chk("sa2.used", s_used, 2);
    chk("sa2.rddone", s_rddone, 0);
    tick();
    chk("sa3.rddata", s_rddata, 8'hA5);
    s_rden = 1;
    tick();
    s_rden = 0;
    $display("sa txn read rddata=%02h", s_rddata);
    chk("sa4.rddone", s_rddone, 1); chk("sa4.rddata", s_rddata, 8'h3C);
    chk("sa4.used", s_used, 1);
    tick();
    chk("sa5.rddone", s_rddone, 0); chk("sa5.rddata", s_rddata, 8'h3C);
    s_rden = 1;
    tick();
    s_rden = 0;
    $display("sa txn read used=%0d", s_used);
    chk("sa6.rddone", s_rddone, 1); chk("sa6.empty", s_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
